sliding_window_agg: RTL and testbench
=====================================

Name: sliding_window_agg

Overview:
Parametrised sliding-window aggregation unit for the generated RTLola monitors. It generalises the fixed 3-bucket event-in/periodic-out window to N buckets, configurable width and slide period, and a selectable aggregation mode. Event-based input samples accumulate into the current bucket. An internal period timer slides the window and emits one aggregate per period. It sits between the input event queue and the periodic output-stream evaluator.

Parameters:
DATA_W, 64, width of input samples and aggregate; signed two's complement
NUM_BUCKETS, 3, window length in slide periods (>=1)
SLIDE_PERIOD, 500, clock cycles per slide (>=2)
MODE, 0, 0=sum, 1=count, 2=signed max

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
en  in  1  global enable; low freezes all state
in_data  in  DATA_W  input sample (signed)
in_valid  in  1  one-cycle pulse: in_data is a new event
out_value  out  DATA_W  window aggregate (signed)
out_valid  out  1  one-cycle pulse: out_value updated
out_empty  out  1  window held no events at last slide
timer  out  32  current period counter, for debug/trace

Behaviour:
- Reset (rst==0 at posedge): all buckets cleared and marked empty, timer=0, out_value=0, out_valid=0, out_empty=1. Reset mid-window discards all contents; the next period starts cleanly the cycle after release.
- en==0: timer, buckets and outputs hold; in_valid ignored; out_valid forced 0.
- Timer: counts 0..SLIDE_PERIOD-1 while en, then wraps to 0. The slide cycle is the cycle where timer==SLIDE_PERIOD-1.
- Event (in_valid & en) updates the current bucket as follows:
  - sum: bucket += in_data, wrapping mod 2^DATA_W.
  - count: bucket += 1, wrapping.
  - max: bucket = max(bucket, in_data) if the bucket is non-empty, else in_data.
  - In all modes the bucket's non-empty flag is set.
- Slide cycle:
  - out_value is registered as the aggregate over all NUM_BUCKETS buckets. The current bucket is included.
  - An event arriving on the slide cycle is included in this output, not the next.
  - Buckets then shift: the oldest is dropped and the current becomes empty with identity value 0.
- Empty handling: empty buckets are excluded from max. If all buckets are empty, out_value=0 and out_empty=1; otherwise out_empty=0.
- Latency: out_valid pulses exactly one cycle after the slide cycle. The first pulse comes SLIDE_PERIOD cycles after reset release with en held high.
- Windows are not pre-filled: the first NUM_BUCKETS-1 outputs cover fewer periods.
- Event input is never back-pressured. At most one event per cycle.

Optional Feature:
- Macro: SLIDING_WINDOW_AVG_EN.
- When defined:
  - MODE=3 (average) is legal. The unit tracks a per-bucket sum and a per-bucket count.
  - At slide, a sequential restoring divider computes window sum / window count, signed and truncating toward zero, over DATA_W cycles.
  - out_valid is delayed to DATA_W+1 cycles after the slide cycle.
  - Count==0 gives out_value=0 and out_empty=1.
  - SLIDE_PERIOD must be > DATA_W+2. A new slide while the divider is busy is impossible by this constraint.
  - rst aborts the divider.
- When not defined: MODE=3 elaborates as MODE=0, and no divider or count storage is built.

Test Plan:
1. Idle window: NUM_BUCKETS=3, SLIDE_PERIOD=8, MODE=0, no events, en=1 after reset -> out_valid pulses at cycles 8, 16, 24; out_value=0; out_empty=1.
2. Sum sliding: one event per period with values 1,2,3,4,5 -> outputs 1,3,6,9,12; out_empty=0.
3. Slide-cycle coincidence: event 7 on the slide cycle plus event 1 earlier in the same period -> that output=8; the next empty period gives 8, not 7-shifted.
4. Max with negatives, MODE=2: events -5, -2, -9 in periods 1-3, none after -> outputs -5, -2, -2, -2, -9, then 0 with out_empty=1.
5. Enable/reset: en low for 3 cycles mid-period -> out_valid delayed by 3 cycles, values unchanged. rst low mid-window -> next output 0, out_empty=1.
6. With SLIDING_WINDOW_AVG_EN, MODE=3, DATA_W=16, SLIDE_PERIOD=32: events 4 and 7 in period 1, then 1 in period 2 -> outputs 5, then 4; out_valid 17 cycles after each slide.

Source files
------------

// File: rtl/sliding_window_agg.sv
// sliding_window_agg: N-bucket sliding-window aggregator for RTLola monitors.
// Events accumulate into the current bucket; every SLIDE_PERIOD cycles the
// window aggregate is registered, out_valid pulses, and the buckets shift.
// MODE: 0=sum, 1=count, 2=signed max, 3=average (only with the optional
// feature enabled by defining SLIDING_WINDOW_AVG_EN; otherwise MODE=3 acts
// as MODE=0 and no divider or count storage is built).
// Handshake: in_valid is a one-cycle event pulse qualified by en, never
// back-pressured; out_valid is a one-cycle pulse marking a new out_value,
// held off while en is low and presented once en returns.
module sliding_window_agg #(
    parameter int DATA_W       = 64,
    parameter int NUM_BUCKETS  = 3,
    parameter int SLIDE_PERIOD = 500,
    parameter int MODE         = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_value,
    output logic              out_valid,
    output logic              out_empty,
    output logic [31:0]       timer
);

`ifdef SLIDING_WINDOW_AVG_EN
    localparam int EFF_MODE = MODE;
`else
    localparam int EFF_MODE = (MODE == 3) ? 0 : MODE;
`endif

    localparam logic [31:0]       LAST_TICK = 32'(SLIDE_PERIOD - 1);
    localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);

    // bucket 0 is the current (filling) bucket, NUM_BUCKETS-1 the oldest
    logic [DATA_W-1:0]      bucket_val [NUM_BUCKETS];
    logic [NUM_BUCKETS-1:0] bucket_ne;

    // window as seen on this cycle, with this cycle's event folded in
    logic [DATA_W-1:0]      win_val [NUM_BUCKETS];
    logic [NUM_BUCKETS-1:0] win_ne;

    logic              event_hit;
    logic              slide;
    logic [DATA_W-1:0] cur_val_upd;
    logic [DATA_W-1:0] agg_val;
    logic              agg_any;
    logic              valid_q;

    assign event_hit = en & in_valid;
    assign slide     = en & (timer == LAST_TICK);
    assign out_valid = valid_q & en;

    // period timer: 0..SLIDE_PERIOD-1, frozen while en is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer <= '0;
        end else if (en) begin
            timer <= slide ? 32'd0 : timer + 32'd1;
        end
    end

    // fold the incoming event into the current bucket value
    always_comb begin
        cur_val_upd = bucket_val[0];
        if (event_hit) begin
            if (EFF_MODE == 1) begin
                cur_val_upd = bucket_val[0] + ONE;
            end else if (EFF_MODE == 2) begin
                if (!bucket_ne[0] || ($signed(in_data) > $signed(bucket_val[0]))) begin
                    cur_val_upd = in_data;
                end
            end else begin
                cur_val_upd = bucket_val[0] + in_data;
            end
        end
    end

    // build the effective window and reduce it to one aggregate
    always_comb begin
        win_val    = bucket_val;
        win_val[0] = cur_val_upd;
        win_ne     = bucket_ne;
        win_ne[0]  = bucket_ne[0] | event_hit;
        agg_val    = '0;
        agg_any    = 1'b0;
        for (int i = 0; i < NUM_BUCKETS; i++) begin
            if (EFF_MODE == 2) begin
                // empty buckets hold 0 and must not win a max over negatives
                if (win_ne[i] && (!agg_any || ($signed(win_val[i]) > $signed(agg_val)))) begin
                    agg_val = win_val[i];
                end
            end else begin
                agg_val = agg_val + win_val[i];
            end
            agg_any = agg_any | win_ne[i];
        end
    end

    // bucket storage: accumulate into bucket 0, shift the window on slide
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BUCKETS; i++) begin
                bucket_val[i] <= '0;
            end
            bucket_ne <= '0;
        end else if (en) begin
            if (slide) begin
                for (int i = NUM_BUCKETS - 1; i > 0; i--) begin
                    bucket_val[i] <= win_val[i-1];
                end
                bucket_val[0] <= '0;
                bucket_ne     <= win_ne << 1;
            end else begin
                bucket_val[0] <= cur_val_upd;
                bucket_ne[0]  <= win_ne[0];
            end
        end
    end

    if (EFF_MODE != 3) begin : g_direct
        // register the aggregate on the slide cycle; pulse valid next cycle
        always_ff @(posedge clk) begin
            if (!rst) begin
                out_value <= '0;
                out_empty <= 1'b1;
                valid_q   <= 1'b0;
            end else if (en) begin
                valid_q <= slide;
                if (slide) begin
                    out_value <= agg_any ? agg_val : '0;
                    out_empty <= ~agg_any;
                end
            end
        end
    end

`ifdef SLIDING_WINDOW_AVG_EN
    if (EFF_MODE == 3) begin : g_avg
        logic [DATA_W-1:0] bucket_cnt [NUM_BUCKETS];
        logic [DATA_W-1:0] win_cnt    [NUM_BUCKETS];
        logic [DATA_W-1:0] agg_cnt;

        logic              div_busy;
        logic [31:0]       div_left;
        logic [DATA_W-1:0] div_rem;
        logic [DATA_W-1:0] div_quo;
        logic [DATA_W-1:0] div_den;
        logic              div_neg;
        logic              div_zero;
        logic [DATA_W:0]   rem_shift;
        logic [DATA_W:0]   rem_diff;
        logic              rem_fits;
        logic [DATA_W-1:0] rem_next;
        logic [DATA_W-1:0] quo_next;

        // per-bucket event counts, window total including this cycle's event
        always_comb begin
            win_cnt = bucket_cnt;
            if (event_hit) begin
                win_cnt[0] = bucket_cnt[0] + ONE;
            end
            agg_cnt = '0;
            for (int i = 0; i < NUM_BUCKETS; i++) begin
                agg_cnt = agg_cnt + win_cnt[i];
            end
        end

        // count storage shifts in lockstep with the sum buckets
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < NUM_BUCKETS; i++) begin
                    bucket_cnt[i] <= '0;
                end
            end else if (en) begin
                if (slide) begin
                    for (int i = NUM_BUCKETS - 1; i > 0; i--) begin
                        bucket_cnt[i] <= win_cnt[i-1];
                    end
                    bucket_cnt[0] <= '0;
                end else begin
                    bucket_cnt[0] <= win_cnt[0];
                end
            end
        end

        // one restoring step on magnitudes: shift in a dividend bit, try subtract
        always_comb begin
            rem_shift = {div_rem, div_quo[DATA_W-1]};
            rem_diff  = rem_shift - {1'b0, div_den};
            rem_fits  = ~rem_diff[DATA_W];
            rem_next  = rem_fits ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
            quo_next  = DATA_W'({div_quo, rem_fits});
        end

        // divider sequencing: load on slide, DATA_W steps, then publish
        always_ff @(posedge clk) begin
            if (!rst) begin
                div_busy  <= 1'b0;
                div_left  <= '0;
                div_rem   <= '0;
                div_quo   <= '0;
                div_den   <= '0;
                div_neg   <= 1'b0;
                div_zero  <= 1'b1;
                out_value <= '0;
                out_empty <= 1'b1;
                valid_q   <= 1'b0;
            end else if (en) begin
                valid_q <= 1'b0;
                if (slide) begin
                    div_busy <= 1'b1;
                    div_left <= 32'(DATA_W);
                    div_rem  <= '0;
                    div_quo  <= agg_val[DATA_W-1] ? (-agg_val) : agg_val;
                    div_den  <= agg_cnt;
                    div_neg  <= agg_val[DATA_W-1];
                    div_zero <= (agg_cnt == '0) | ~agg_any;
                end else if (div_busy) begin
                    div_rem  <= rem_next;
                    div_quo  <= quo_next;
                    div_left <= div_left - 32'd1;
                    if (div_left == 32'd1) begin
                        div_busy  <= 1'b0;
                        valid_q   <= 1'b1;
                        out_empty <= div_zero;
                        if (div_zero) begin
                            out_value <= '0;
                        end else begin
                            out_value <= div_neg ? (-quo_next) : quo_next;
                        end
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sliding_window_agg.sv
// Directed bench for sliding_window_agg: sum, count and max instances share
// one stimulus stream (period 8, 3 buckets, 16-bit data); an average
// instance (period 32) is added when SLIDING_WINDOW_AVG_EN is defined.
module tb_sliding_window_agg;

    localparam int W = 16;

    typedef struct packed {
        logic [1:0]   id;
        logic [31:0]  cyc;
        logic         emp;
        logic [W-1:0] val;
    } obs_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] in_data;
    logic         in_valid;

    logic [W-1:0] s_value, c_value, m_value;
    logic         s_valid, c_valid, m_valid;
    logic         s_empty, c_empty, m_empty;
    logic [31:0]  s_timer, c_timer, m_timer;

    obs_t         obs_q[$];
    logic [W-1:0] exp_q[$];
    logic         exp_e_q[$];
    logic [31:0]  exp_c_q[$];
    logic [31:0]  cyc_cnt;
    int           total;
    int           bad;

    sliding_window_agg #(.DATA_W(W), .NUM_BUCKETS(3), .SLIDE_PERIOD(8), .MODE(0)) u_sum (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .out_value(s_value), .out_valid(s_valid), .out_empty(s_empty), .timer(s_timer)
    );

    sliding_window_agg #(.DATA_W(W), .NUM_BUCKETS(3), .SLIDE_PERIOD(8), .MODE(1)) u_cnt (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .out_value(c_value), .out_valid(c_valid), .out_empty(c_empty), .timer(c_timer)
    );

    sliding_window_agg #(.DATA_W(W), .NUM_BUCKETS(3), .SLIDE_PERIOD(8), .MODE(2)) u_max (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .out_value(m_value), .out_valid(m_valid), .out_empty(m_empty), .timer(m_timer)
    );

`ifdef SLIDING_WINDOW_AVG_EN
    logic [W-1:0] a_value;
    logic         a_valid;
    logic         a_empty;
    logic [31:0]  a_timer;

    sliding_window_agg #(.DATA_W(W), .NUM_BUCKETS(3), .SLIDE_PERIOD(32), .MODE(3)) u_avg (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .out_value(a_value), .out_valid(a_valid), .out_empty(a_empty), .timer(a_timer)
    );
`endif

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // drive one cycle of inputs, then record any output pulses of that next cycle
    task automatic step(input logic e, input logic v, input logic [W-1:0] d);
        en       = e;
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        cyc_cnt++;
        if (s_valid) obs_q.push_back('{id: 2'd0, cyc: cyc_cnt, emp: s_empty, val: s_value});
        if (c_valid) obs_q.push_back('{id: 2'd1, cyc: cyc_cnt, emp: c_empty, val: c_value});
        if (m_valid) obs_q.push_back('{id: 2'd2, cyc: cyc_cnt, emp: m_empty, val: m_value});
`ifdef SLIDING_WINDOW_AVG_EN
        if (a_valid) obs_q.push_back('{id: 2'd3, cyc: cyc_cnt, emp: a_empty, val: a_value});
`endif
    endtask

    // rst low for two edges; the next step drives cycle 0 of the new run
    task automatic do_reset();
        rst = 1'b0;
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        obs_q.delete();
        rst     = 1'b1;
        cyc_cnt = 0;
    endtask

    // one aligned 8-cycle period: optional event at timer 2 and at the slide cycle
    task automatic period(input logic v_mid, input logic [W-1:0] d_mid,
                          input logic v_last, input logic [W-1:0] d_last);
        for (int t = 0; t < 8; t++) begin
            if (t == 2)      step(1'b1, v_mid, d_mid);
            else if (t == 7) step(1'b1, v_last, d_last);
            else             step(1'b1, 1'b0, '0);
        end
    endtask

    task automatic expect_out(input logic [W-1:0] v, input logic e, input logic [31:0] c);
        exp_q.push_back(v);
        exp_e_q.push_back(e);
        exp_c_q.push_back(c);
    endtask

    // compare recorded pulses of one instance against the expected queue
    task automatic score(input string tag, input logic [1:0] id);
        int n_obs;
        n_obs = 0;
        foreach (obs_q[i]) if (obs_q[i].id == id) n_obs++;
        check({tag, "_pulses"}, 32'(n_obs), 32'(exp_q.size()));
        foreach (obs_q[i]) begin
            if (obs_q[i].id == id && exp_q.size() > 0) begin
                check({tag, "_val"}, 32'(obs_q[i].val), 32'(exp_q.pop_front()));
                check({tag, "_emp"}, 32'(obs_q[i].emp), 32'(exp_e_q.pop_front()));
                check({tag, "_cyc"}, obs_q[i].cyc, exp_c_q.pop_front());
            end
        end
        exp_q.delete();
        exp_e_q.delete();
        exp_c_q.delete();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc_cnt  = 0;
        rst      = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);

        // reset state
        do_reset();
        check("rst_timer", s_timer, 32'd0);
        check("rst_value", 32'(s_value), 32'd0);
        check("rst_empty", 32'(s_empty), 32'd1);
        check("rst_valid", 32'(s_valid), 32'd0);

        // idle window: empty pulses at 8, 16, 24
        for (int p = 0; p < 3; p++) period(1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        for (int p = 1; p <= 3; p++) expect_out('0, 1'b1, 32'(8 * p));
        score("idle_sum", 2'd0);
        for (int p = 1; p <= 3; p++) expect_out('0, 1'b1, 32'(8 * p));
        score("idle_max", 2'd2);

        // one event per period, values 1..5
        do_reset();
        for (int p = 1; p <= 5; p++) period(1'b1, W'(p), 1'b0, '0);
        step(1'b1, 1'b0, '0);
        expect_out(16'd1, 1'b0, 32'd8);
        expect_out(16'd3, 1'b0, 32'd16);
        expect_out(16'd6, 1'b0, 32'd24);
        expect_out(16'd9, 1'b0, 32'd32);
        expect_out(16'd12, 1'b0, 32'd40);
        score("sum_slide", 2'd0);
        expect_out(16'd1, 1'b0, 32'd8);
        expect_out(16'd2, 1'b0, 32'd16);
        expect_out(16'd3, 1'b0, 32'd24);
        expect_out(16'd3, 1'b0, 32'd32);
        expect_out(16'd3, 1'b0, 32'd40);
        score("cnt_slide", 2'd1);

        // event on the slide cycle belongs to the closing period
        do_reset();
        period(1'b1, 16'd1, 1'b1, 16'd7);
        period(1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        expect_out(16'd8, 1'b0, 32'd8);
        expect_out(16'd8, 1'b0, 32'd16);
        score("coinc_sum", 2'd0);
        expect_out(16'd2, 1'b0, 32'd8);
        expect_out(16'd2, 1'b0, 32'd16);
        score("coinc_cnt", 2'd1);
        expect_out(16'd7, 1'b0, 32'd8);
        expect_out(16'd7, 1'b0, 32'd16);
        score("coinc_max", 2'd2);

        // negatives: -5, -2, -9 then three empty periods
        do_reset();
        period(1'b1, 16'hFFFB, 1'b0, '0);
        period(1'b1, 16'hFFFE, 1'b0, '0);
        period(1'b1, 16'hFFF7, 1'b0, '0);
        for (int p = 0; p < 3; p++) period(1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        expect_out(16'hFFFB, 1'b0, 32'd8);
        expect_out(16'hFFFE, 1'b0, 32'd16);
        expect_out(16'hFFFE, 1'b0, 32'd24);
        expect_out(16'hFFFE, 1'b0, 32'd32);
        expect_out(16'hFFF7, 1'b0, 32'd40);
        expect_out(16'h0000, 1'b1, 32'd48);
        score("neg_max", 2'd2);
        expect_out(16'hFFFB, 1'b0, 32'd8);
        expect_out(16'hFFF9, 1'b0, 32'd16);
        expect_out(16'hFFF0, 1'b0, 32'd24);
        expect_out(16'hFFF5, 1'b0, 32'd32);
        expect_out(16'hFFF7, 1'b0, 32'd40);
        expect_out(16'h0000, 1'b1, 32'd48);
        score("neg_sum", 2'd0);

        // en low 3 cycles mid-period (events offered meanwhile must be ignored)
        do_reset();
        for (int t = 0; t < 8; t++) begin
            if (t == 4) begin
                for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'd100);
                check("en_timer_hold", s_timer, 32'd4);
            end
            step(1'b1, (t == 2), 16'd3);
        end
        period(1'b1, 16'd6, 1'b0, '0);
        for (int t = 0; t < 4; t++) step(1'b1, (t == 1), 16'd9);
        expect_out(16'd3, 1'b0, 32'd11);
        expect_out(16'd9, 1'b0, 32'd19);
        score("en_sum", 2'd0);

        // reset mid-window discards contents
        do_reset();
        check("midrst_timer", s_timer, 32'd0);
        check("midrst_empty", 32'(s_empty), 32'd1);
        period(1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        expect_out('0, 1'b1, 32'd8);
        score("midrst_sum", 2'd0);
        expect_out('0, 1'b1, 32'd8);
        score("midrst_cnt", 2'd1);

`ifdef SLIDING_WINDOW_AVG_EN
        // average: (4+7)/2=5, (11+1)/3=4, (12-30)/4=-4 truncated toward zero
        do_reset();
        for (int c = 0; c < 114; c++) begin
            if (c == 3)       step(1'b1, 1'b1, 16'd4);
            else if (c == 10) step(1'b1, 1'b1, 16'd7);
            else if (c == 40) step(1'b1, 1'b1, 16'd1);
            else if (c == 70) step(1'b1, 1'b1, 16'hFFE2);
            else              step(1'b1, 1'b0, '0);
        end
        expect_out(16'd5, 1'b0, 32'd48);
        expect_out(16'd4, 1'b0, 32'd80);
        expect_out(16'hFFFC, 1'b0, 32'd112);
        score("avg", 2'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
